hazard_stall_unit: RTL and testbench

- Issues the pipeline control that the forwarding unit cannot resolve: load-use stalls, jump redirects and branch-resolution stalls.
- Sits beside the ID stage and drives the PC write enable, the IF/ID write enable and flush, the ID/EX bubble insert, and the next-PC address select.
- Contains a branch-wait FSM with a latency counter and a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit_if.sv | 32 +++
 rtl/hazard_stall_unit.sv | 110 +++++++++++
 tb/tb_hazard_stall_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Pipeline control bundle between the ID-stage decode/hazard inputs and the stall unit.
// master drives the decoded fields, slave (the stall unit) drives the control outputs.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UseRt;
  logic             ID_Jump;
  logic             ID_Branch;
  logic [4:0]       EX_Rw;
  logic             EX_MemRead;
  logic             EX_BranchTaken;
  logic             PCWrite;
  logic             IFWrite;
  logic             IFFlush;
  logic             Bubble;
  logic [1:0]       AddrSel;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UseRt, ID_Jump, ID_Branch,
    output EX_Rw, EX_MemRead, EX_BranchTaken,
    input  PCWrite, IFWrite, IFFlush, Bubble, AddrSel, StallCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRt, ID_Jump, ID_Branch,
    input  EX_Rw, EX_MemRead, EX_BranchTaken,
    output PCWrite, IFWrite, IFFlush, Bubble, AddrSel, StallCount
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / jump / branch-wait stall control for a classic 5-stage pipeline.
// Control outputs are Mealy; StallCount is a registered saturating count of PC-hold cycles.
module hazard_stall_unit #(
  parameter int BRANCH_LAT = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  hazard_stall_unit_if.slave bus
);

  localparam int LAT_W = (BRANCH_LAT > 1) ? $clog2(BRANCH_LAT) : 1;

  typedef enum logic {
    IDLE,
    BR_WAIT
  } state_t;

  state_t           r_state;
  logic [LAT_W-1:0] r_latCnt;
  logic [CNT_W-1:0] r_stallCount;

  logic       w_loadUse;
  logic       w_pcWrite;
  logic       w_ifWrite;
  logic       w_ifFlush;
  logic       w_bubble;
  logic [1:0] w_addrSel;

  assign w_loadUse = bus.EX_MemRead && (bus.EX_Rw != 5'd0) &&
                     ((bus.EX_Rw == bus.ID_Rs) ||
                      (bus.ID_UseRt && (bus.EX_Rw == bus.ID_Rt)));

  always_comb begin
    w_pcWrite = 1'b1;
    w_ifWrite = 1'b1;
    w_ifFlush = 1'b0;
    w_bubble  = 1'b0;
    w_addrSel = 2'b00;
    if (rst) begin
      w_pcWrite = 1'b0;
      w_ifWrite = 1'b0;
      w_bubble  = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_loadUse) begin
            w_pcWrite = 1'b0;
            w_ifWrite = 1'b0;
            w_bubble  = 1'b1;
          end else if (bus.ID_Jump) begin
            w_addrSel = 2'b01;
            w_ifFlush = 1'b1;
          end else if (bus.ID_Branch) begin
            w_pcWrite = 1'b0;
            w_ifWrite = 1'b0;
          end
        end
        BR_WAIT: begin
          // IF/ID still holds the branch, so every BR_WAIT cycle must bubble ID/EX
          w_bubble = 1'b1;
          if (r_latCnt != '0) begin
            w_pcWrite = 1'b0;
            w_ifWrite = 1'b0;
          end else if (bus.EX_BranchTaken) begin
            w_addrSel = 2'b10;
            w_ifFlush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_latCnt     <= '0;
      r_stallCount <= '0;
    end else begin
      if (!w_pcWrite && (r_stallCount != {CNT_W{1'b1}})) begin
        r_stallCount <= r_stallCount + CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (!w_loadUse && !bus.ID_Jump && bus.ID_Branch) begin
            r_state  <= BR_WAIT;
            r_latCnt <= LAT_W'(BRANCH_LAT - 1);
          end
        end
        BR_WAIT: begin
          if (r_latCnt != '0) begin
            r_latCnt <= r_latCnt - LAT_W'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.PCWrite    = w_pcWrite;
  assign bus.IFWrite    = w_ifWrite;
  assign bus.IFFlush    = w_ifFlush;
  assign bus.Bubble     = w_bubble;
  assign bus.AddrSel    = w_addrSel;
  assign bus.StallCount = r_stallCount;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: dutA (BRANCH_LAT=1, CNT_W=4) for load-use/jump/branch/saturation,
// dutB (BRANCH_LAT=3, CNT_W=16) for async reset in the middle of a branch wait.
module tb_hazard_stall_unit;

  logic clk;
  logic rstA;
  logic rstB;

  int vectors;
  int miscompares;

  // Packed control expectations: {PCWrite, IFWrite, IFFlush, Bubble, AddrSel}
  localparam logic [5:0] CTL_DEF   = 6'b110000;
  localparam logic [5:0] CTL_STALL = 6'b000100;
  localparam logic [5:0] CTL_JUMP  = 6'b111001;
  localparam logic [5:0] CTL_BRIN  = 6'b000000;
  localparam logic [5:0] CTL_TAKEN = 6'b111110;
  localparam logic [5:0] CTL_NOTTK = 6'b110100;
  localparam logic [5:0] CTL_RESET = 6'b000100;

  hazard_stall_unit_if #(.CNT_W(4))  ifA ();
  hazard_stall_unit_if #(.CNT_W(16)) ifB ();

  hazard_stall_unit #(.BRANCH_LAT(1), .CNT_W(4)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (ifA.slave)
  );

  hazard_stall_unit #(.BRANCH_LAT(3), .CNT_W(16)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (ifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkA(input string tag, input logic [5:0] expCtl, input int expCount);
    checkOutput({tag, "_ctl"}, 32'({ifA.PCWrite, ifA.IFWrite, ifA.IFFlush, ifA.Bubble, ifA.AddrSel}),
                32'(expCtl));
    checkOutput({tag, "_cnt"}, 32'(ifA.StallCount), 32'(expCount));
  endtask

  task automatic checkB(input string tag, input logic [5:0] expCtl, input int expCount);
    checkOutput({tag, "_ctl"}, 32'({ifB.PCWrite, ifB.IFWrite, ifB.IFFlush, ifB.Bubble, ifB.AddrSel}),
                32'(expCtl));
    checkOutput({tag, "_cnt"}, 32'(ifB.StallCount), 32'(expCount));
  endtask

  // Advance one rising edge, then move 2 time units past it before driving inputs
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clearA();
    ifA.ID_Rs = 5'd0; ifA.ID_Rt = 5'd0; ifA.ID_UseRt = 1'b0;
    ifA.ID_Jump = 1'b0; ifA.ID_Branch = 1'b0;
    ifA.EX_Rw = 5'd0; ifA.EX_MemRead = 1'b0; ifA.EX_BranchTaken = 1'b0;
  endtask

  task automatic clearB();
    ifB.ID_Rs = 5'd0; ifB.ID_Rt = 5'd0; ifB.ID_UseRt = 1'b0;
    ifB.ID_Jump = 1'b0; ifB.ID_Branch = 1'b0;
    ifB.EX_Rw = 5'd0; ifB.EX_MemRead = 1'b0; ifB.EX_BranchTaken = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstA = 1'b1;
    rstB = 1'b1;
    clearA();
    clearB();

    #12;
    checkA("resetA", CTL_RESET, 0);
    checkB("resetB", CTL_RESET, 0);
    rstA = 1'b0;
    rstB = 1'b0;
    #1;
    checkA("idleA", CTL_DEF, 0);
    applyStimulus(1);

    // Load-use on rs: single stall cycle, then defaults
    ifA.EX_MemRead = 1'b1; ifA.EX_Rw = 5'd5; ifA.ID_Rs = 5'd5;
    #1 checkA("luRs", CTL_STALL, 0);
    applyStimulus(1);
    ifA.EX_MemRead = 1'b0;
    #1 checkA("luRsAfter", CTL_DEF, 1);

    // rt only matters when the instruction actually reads rt
    clearA();
    ifA.EX_MemRead = 1'b1; ifA.EX_Rw = 5'd7; ifA.ID_Rt = 5'd7; ifA.ID_Rs = 5'd3;
    #1 checkA("luRtNoUse", CTL_DEF, 1);
    ifA.ID_UseRt = 1'b1;
    #1 checkA("luRtUse", CTL_STALL, 1);
    applyStimulus(1);

    // $zero is never a hazard
    clearA();
    ifA.EX_MemRead = 1'b1; ifA.EX_Rw = 5'd0; ifA.ID_Rs = 5'd0; ifA.ID_UseRt = 1'b1;
    #1 checkA("luZero", CTL_DEF, 2);
    applyStimulus(1);

    // Jump: same-cycle redirect, no stall, stays IDLE
    clearA();
    ifA.ID_Jump = 1'b1;
    #1 checkA("jump", CTL_JUMP, 2);
    applyStimulus(1);
    ifA.ID_Jump = 1'b0;
    #1 checkA("jumpAfter", CTL_DEF, 2);

    // Branch taken with BRANCH_LAT=1
    ifA.ID_Branch = 1'b1;
    #1 checkA("brEnterT", CTL_BRIN, 2);
    applyStimulus(1);
    ifA.EX_BranchTaken = 1'b1;
    #1 checkA("brTaken", CTL_TAKEN, 3);
    applyStimulus(1);
    clearA();
    #1 checkA("brTakenAfter", CTL_DEF, 3);

    // Branch not taken with BRANCH_LAT=1
    ifA.ID_Branch = 1'b1;
    #1 checkA("brEnterN", CTL_BRIN, 3);
    applyStimulus(1);
    ifA.EX_BranchTaken = 1'b0;
    #1 checkA("brNotTaken", CTL_NOTTK, 4);
    applyStimulus(1);
    clearA();
    #1 checkA("brNotTakenAfter", CTL_DEF, 4);

    // Load-use wins over a jump; the jump acts on the next cycle
    ifA.EX_MemRead = 1'b1; ifA.EX_Rw = 5'd9; ifA.ID_Rs = 5'd9; ifA.ID_Jump = 1'b1;
    #1 checkA("luOverJump", CTL_STALL, 4);
    applyStimulus(1);
    ifA.EX_MemRead = 1'b0;
    #1 checkA("jumpAfterLu", CTL_JUMP, 5);
    applyStimulus(1);

    // Saturation of the 4-bit counter under continuous load-use stalls
    clearA();
    ifA.EX_MemRead = 1'b1; ifA.EX_Rw = 5'd5; ifA.ID_Rs = 5'd5;
    applyStimulus(9);
    #1 checkA("sat14", CTL_STALL, 14);
    applyStimulus(1);
    #1 checkA("sat15", CTL_STALL, 15);
    applyStimulus(10);
    #1 checkA("satHold", CTL_STALL, 15);
    clearA();

    // dutB: BRANCH_LAT=3, reset asynchronously in the second BR_WAIT cycle
    ifB.ID_Branch = 1'b1;
    #1 checkB("bEnter", CTL_BRIN, 0);
    applyStimulus(1);
    #1 checkB("bWait1", CTL_STALL, 1);
    applyStimulus(1);
    #1 checkB("bWait2", CTL_STALL, 2);
    ifB.EX_BranchTaken = 1'b1;
    ifB.ID_Branch = 1'b0;
    rstB = 1'b1;
    #1 checkB("bAsyncRst", CTL_RESET, 0);
    applyStimulus(1);
    #1 checkB("bRstHeld", CTL_RESET, 0);
    rstB = 1'b0;
    #1 checkB("bAfterRst", CTL_DEF, 0);
    applyStimulus(1);
    #1 checkB("bNoRedirect", CTL_DEF, 0);
    applyStimulus(1);
    #1 checkB("bStillIdle", CTL_DEF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
